ble_ll_pdu_decoder: RTL and testbench
=====================================

Name: ble_ll_pdu_decoder

Overview:
Parametrised BLE link-layer PDU decoder for the packet sniffer. It consumes the de-whitened byte stream that follows the access address and parses the 2-byte header, the optional advertiser address and the payload. Payload bytes are forwarded as a stream, the real CRC-24 is checked, and a per-packet status pulse is issued to the capture/host logic. It supersedes the fixed 6-byte-address, 32-byte-payload decoder and adds a true CRC, length checking, mid-packet restart and a BLE 5 length mode.

Parameters:
MAX_PAYLOAD, 37, largest accepted length field in bytes (1..255).
LEN_BITS, 6, header length field width: 6 = BLE 4.x, 8 = BLE 5.
ADDR_EN, 1, 1 = first 6 payload bytes are captured as adv_addr (little-endian).
CRC_INIT, 24'h555555, CRC-24 register preset at each sop.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  PDU byte, LSB = first bit on air
in_valid  input  1  in_data valid this cycle
in_sop  input  1  qualifies in_valid: byte is header byte 0
pl_data  output  8  forwarded payload byte
pl_valid  output  1  pl_data valid
pl_last  output  1  last payload byte
pdu_type  output  4  header[3:0]
tx_add  output  1  header[6]
rx_add  output  1  header[7]
pdu_len  output  8  length field, zero-extended
adv_addr  output  48  byte0 in [7:0]
addr_valid  output  1  adv_addr captured for this packet
pkt_done  output  1  one-cycle pulse, packet complete
crc_error  output  1  valid with pkt_done
len_error  output  1  one-cycle pulse, packet dropped: length > MAX_PAYLOAD
abort  output  1  one-cycle pulse, packet truncated by a new sop

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register = CRC_INIT; counters 0. Async assert, sync release.
- Only cycles with in_valid=1 advance the FSM. Gaps of any length are legal.
- States: IDLE, HDR1, ADDR, PAYLOAD, CRC, DONE.
- in_sop && in_valid from any state (IDLE included):
  - Capture pdu_type, tx_add and rx_add from in_data.
  - Preset CRC to CRC_INIT, then fold in this byte.
  - Clear addr_valid; go to HDR1.
  - If the state was not IDLE or DONE, pulse abort in the same cycle; the old packet gets no pkt_done.
- in_valid without in_sop while in IDLE: ignored.
- HDR1: pdu_len = in_data[LEN_BITS-1:0]. Then:
  - len > MAX_PAYLOAD: pulse len_error, go to IDLE.
  - len == 0: go to CRC.
  - otherwise: go to ADDR if ADDR_EN and len >= 6, else PAYLOAD.
- ADDR: store the byte at adv_addr[8*i+:8] for i = 0..5 and forward it on pl_*. After byte 5, set addr_valid=1 and go to PAYLOAD, or to CRC if len == 6.
- PAYLOAD: forward each byte until the total payload byte count equals pdu_len, then go to CRC.
- Payload streaming:
  - pl_valid is registered, so the forwarded byte appears one cycle after the input byte.
  - pl_last is asserted with the byte whose count equals pdu_len.
  - There is no backpressure.
- CRC-24 (BLE polynomial 0x00065B):
  - Every header, payload and CRC byte is folded in LSB first, one bit at a time: fb = crc[23]^bit; crc = (crc<<1) ^ (fb ? 24'h00065B : 0).
  - All 8 bits of a byte are folded in the byte's valid cycle (combinational unroll).
- CRC state: accept 3 bytes (counter 0..2). After the third byte, go to DONE.
- DONE:
  - pkt_done=1 for exactly one cycle, registered, i.e. the cycle after the third CRC byte.
  - crc_error = (final register != 0). It is held until the next sop.
  - Return to IDLE the next cycle, without waiting for in_valid.
- pdu_type, tx_add, rx_add, pdu_len and adv_addr hold their values until overwritten by the next packet.
- Counter widths: the payload counter is 8 bits, so len=255 never wraps.
- Simultaneous events: in_sop on the cycle after the last CRC byte:
  - pkt_done is still issued.
  - The new packet starts and abort is not raised.

Test Plan:
- ADV_IND, header 0x40 0x09, AdvA 11 22 33 44 55 66, data AA BB CC, correct CRC from bench model -> pdu_type=0, tx_add=1, pdu_len=9, adv_addr=48'h665544332211, addr_valid=1, 9 pl bytes with pl_last on CC, pkt_done with crc_error=0.
- Same packet with one bit flipped in payload byte AA -> identical parse, crc_error=1.
- MAX_PAYLOAD=37, header 0x00 0x26 -> len_error pulse, no pl_valid, no pkt_done; FSM returns to IDLE and the next valid packet decodes cleanly.
- Sop injected after 4 address bytes, followed by a full valid packet -> abort pulse on that cycle, addr_valid=0 until the new address completes, then pkt_done with crc_error=0.
- Empty PDU header 0x01 0x00 plus CRC; random in_valid gaps of 0..5 cycles -> no pl_valid, addr_valid=0, pkt_done with crc_error=0.
- LEN_BITS=8, MAX_PAYLOAD=255, len=255 packet -> 255 pl bytes, no counter wrap, pkt_done with crc_error=0; rst_n asserted mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/ble_ll_pdu_decoder.sv
// BLE link-layer PDU decoder: parses header, optional AdvA and payload of the
// de-whitened PDU byte stream, forwards payload bytes and checks the CRC-24 trailer.
module ble_ll_pdu_decoder #(
  parameter int unsigned MAX_PAYLOAD = 37,
  parameter int unsigned LEN_BITS    = 6,
  parameter bit          ADDR_EN     = 1'b1,
  parameter logic [23:0] CRC_INIT    = 24'h555555
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_sop_i,
  output logic [7:0]  pl_data_o,
  output logic        pl_valid_o,
  output logic        pl_last_o,
  output logic [3:0]  pdu_type_o,
  output logic        tx_add_o,
  output logic        rx_add_o,
  output logic [7:0]  pdu_len_o,
  output logic [47:0] adv_addr_o,
  output logic        addr_valid_o,
  output logic        pkt_done_o,
  output logic        crc_error_o,
  output logic        len_error_o,
  output logic        abort_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_ADDR, S_PAYLOAD, S_CRC, S_DONE
  } state_t;

  // All 8 bits of a byte, LSB first, through the 0x00065B LFSR.
  function automatic logic [23:0] crc_fold(input logic [23:0] crc, input logic [7:0] b);
    logic [23:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[23] ^ b[i]) c = {c[22:0], 1'b0} ^ 24'h00065B;
      else              c = {c[22:0], 1'b0};
    end
    return c;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [23:0] crc_q, crc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  crc_cnt_q, crc_cnt_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d;
  logic        pl_last_q, pl_last_d;
  logic [3:0]  pdu_type_q, pdu_type_d;
  logic        tx_add_q, tx_add_d;
  logic        rx_add_q, rx_add_d;
  logic [7:0]  pdu_len_q, pdu_len_d;
  logic [47:0] adv_addr_q, adv_addr_d;
  logic        addr_valid_q, addr_valid_d;
  logic        pkt_done_q, pkt_done_d;
  logic        crc_error_q, crc_error_d;
  logic        len_error_q, len_error_d;

  logic [7:0]  len_in;
  logic        len_over;
  logic [8:0]  cnt_inc;
  logic [23:0] crc_next;

  assign len_in   = 8'(in_data_i[LEN_BITS-1:0]);
  assign len_over = 32'(len_in) > MAX_PAYLOAD;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
  assign crc_next = crc_fold(crc_q, in_data_i);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= S_IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      crc_cnt_q    <= '0;
      pl_data_q    <= '0;
      pl_valid_q   <= 1'b0;
      pl_last_q    <= 1'b0;
      pdu_type_q   <= '0;
      tx_add_q     <= 1'b0;
      rx_add_q     <= 1'b0;
      pdu_len_q    <= '0;
      adv_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      crc_error_q  <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      crc_cnt_q    <= crc_cnt_d;
      pl_data_q    <= pl_data_d;
      pl_valid_q   <= pl_valid_d;
      pl_last_q    <= pl_last_d;
      pdu_type_q   <= pdu_type_d;
      tx_add_q     <= tx_add_d;
      rx_add_q     <= rx_add_d;
      pdu_len_q    <= pdu_len_d;
      adv_addr_q   <= adv_addr_d;
      addr_valid_q <= addr_valid_d;
      pkt_done_q   <= pkt_done_d;
      crc_error_q  <= crc_error_d;
      len_error_q  <= len_error_d;
    end
  end

  // DONE falls back to IDLE on its own; a sop there starts the next packet cleanly.
  always_comb begin
    state_d = state_q;
    if (state_q == S_DONE) state_d = S_IDLE;
    if (in_valid_i) begin
      if (in_sop_i) begin
        state_d = S_HDR1;
      end else begin
        case (state_q)
          S_HDR1: begin
            if (len_over)                      state_d = S_IDLE;
            else if (len_in == 8'd0)           state_d = S_CRC;
            else if (ADDR_EN && len_in >= 8'd6) state_d = S_ADDR;
            else                               state_d = S_PAYLOAD;
          end
          S_ADDR:    if (cnt_q == 8'd5) state_d = (pdu_len_q == 8'd6) ? S_CRC : S_PAYLOAD;
          S_PAYLOAD: if (cnt_inc == {1'b0, pdu_len_q}) state_d = S_CRC;
          S_CRC:     if (crc_cnt_q == 2'd2) state_d = S_DONE;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    crc_cnt_d    = crc_cnt_q;
    pl_data_d    = pl_data_q;
    pl_valid_d   = 1'b0;
    pl_last_d    = 1'b0;
    pdu_type_d   = pdu_type_q;
    tx_add_d     = tx_add_q;
    rx_add_d     = rx_add_q;
    pdu_len_d    = pdu_len_q;
    adv_addr_d   = adv_addr_q;
    addr_valid_d = addr_valid_q;
    pkt_done_d   = 1'b0;
    crc_error_d  = crc_error_q;
    len_error_d  = 1'b0;
    abort_o      = 1'b0;
    if (in_valid_i && in_sop_i) begin
      abort_o      = (state_q != S_IDLE) && (state_q != S_DONE);
      pdu_type_d   = in_data_i[3:0];
      tx_add_d     = in_data_i[6];
      rx_add_d     = in_data_i[7];
      crc_d        = crc_fold(CRC_INIT, in_data_i);
      addr_valid_d = 1'b0;
      crc_error_d  = 1'b0;
      cnt_d        = '0;
      crc_cnt_d    = '0;
    end else if (in_valid_i) begin
      case (state_q)
        S_HDR1: begin
          pdu_len_d   = len_in;
          len_error_d = len_over;
          crc_d       = crc_next;
          cnt_d       = '0;
          crc_cnt_d   = '0;
        end
        S_ADDR, S_PAYLOAD: begin
          pl_data_d  = in_data_i;
          pl_valid_d = 1'b1;
          pl_last_d  = (cnt_inc == {1'b0, pdu_len_q});
          cnt_d      = cnt_inc[7:0];
          crc_d      = crc_next;
          if (state_q == S_ADDR) begin
            adv_addr_d[{cnt_q[2:0], 3'b000} +: 8] = in_data_i;
            if (cnt_q == 8'd5) addr_valid_d = 1'b1;
          end
        end
        S_CRC: begin
          crc_d     = crc_next;
          crc_cnt_d = crc_cnt_q + 2'd1;
          if (crc_cnt_q == 2'd2) begin
            pkt_done_d  = 1'b1;
            crc_error_d = (crc_next != 24'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign pl_data_o    = pl_data_q;
  assign pl_valid_o   = pl_valid_q;
  assign pl_last_o    = pl_last_q;
  assign pdu_type_o   = pdu_type_q;
  assign tx_add_o     = tx_add_q;
  assign rx_add_o     = rx_add_q;
  assign pdu_len_o    = pdu_len_q;
  assign adv_addr_o   = adv_addr_q;
  assign addr_valid_o = addr_valid_q;
  assign pkt_done_o   = pkt_done_q;
  assign crc_error_o  = crc_error_q;
  assign len_error_o  = len_error_q;

endmodule

// File: tb/tb_ble_ll_pdu_decoder.sv
// Bench for ble_ll_pdu_decoder: a BLE 4.x instance (A) and a BLE 5 length instance (B),
// driven by directed and randomized packets checked against a packet-level model.
module tb_ble_ll_pdu_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [7:0] in_data;
  logic       in_valid, in_sop;
  logic       sel;
  logic       va, vb;
  assign va = in_valid & ~sel;
  assign vb = in_valid & sel;

  logic [7:0]  a_pl_data, b_pl_data, m_pl_data;
  logic        a_pl_valid, b_pl_valid, m_pl_valid;
  logic        a_pl_last, b_pl_last, m_pl_last;
  logic [3:0]  a_pdu_type, b_pdu_type, m_pdu_type;
  logic        a_tx_add, b_tx_add, m_tx_add;
  logic        a_rx_add, b_rx_add, m_rx_add;
  logic [7:0]  a_pdu_len, b_pdu_len, m_pdu_len;
  logic [47:0] a_adv_addr, b_adv_addr, m_adv_addr;
  logic        a_addr_valid, b_addr_valid, m_addr_valid;
  logic        a_pkt_done, b_pkt_done, m_pkt_done;
  logic        a_crc_error, b_crc_error, m_crc_error;
  logic        a_len_error, b_len_error, m_len_error;
  logic        a_abort, b_abort, m_abort;

  ble_ll_pdu_decoder #(.MAX_PAYLOAD(37), .LEN_BITS(6), .ADDR_EN(1'b1), .CRC_INIT(24'h555555)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_data_i(in_data), .in_valid_i(va), .in_sop_i(in_sop),
    .pl_data_o(a_pl_data), .pl_valid_o(a_pl_valid), .pl_last_o(a_pl_last),
    .pdu_type_o(a_pdu_type), .tx_add_o(a_tx_add), .rx_add_o(a_rx_add), .pdu_len_o(a_pdu_len),
    .adv_addr_o(a_adv_addr), .addr_valid_o(a_addr_valid), .pkt_done_o(a_pkt_done),
    .crc_error_o(a_crc_error), .len_error_o(a_len_error), .abort_o(a_abort));

  ble_ll_pdu_decoder #(.MAX_PAYLOAD(255), .LEN_BITS(8), .ADDR_EN(1'b1), .CRC_INIT(24'h555555)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_data_i(in_data), .in_valid_i(vb), .in_sop_i(in_sop),
    .pl_data_o(b_pl_data), .pl_valid_o(b_pl_valid), .pl_last_o(b_pl_last),
    .pdu_type_o(b_pdu_type), .tx_add_o(b_tx_add), .rx_add_o(b_rx_add), .pdu_len_o(b_pdu_len),
    .adv_addr_o(b_adv_addr), .addr_valid_o(b_addr_valid), .pkt_done_o(b_pkt_done),
    .crc_error_o(b_crc_error), .len_error_o(b_len_error), .abort_o(b_abort));

  assign m_pl_data    = sel ? b_pl_data    : a_pl_data;
  assign m_pl_valid   = sel ? b_pl_valid   : a_pl_valid;
  assign m_pl_last    = sel ? b_pl_last    : a_pl_last;
  assign m_pdu_type   = sel ? b_pdu_type   : a_pdu_type;
  assign m_tx_add     = sel ? b_tx_add     : a_tx_add;
  assign m_rx_add     = sel ? b_rx_add     : a_rx_add;
  assign m_pdu_len    = sel ? b_pdu_len    : a_pdu_len;
  assign m_adv_addr   = sel ? b_adv_addr   : a_adv_addr;
  assign m_addr_valid = sel ? b_addr_valid : a_addr_valid;
  assign m_pkt_done   = sel ? b_pkt_done   : a_pkt_done;
  assign m_crc_error  = sel ? b_crc_error  : a_crc_error;
  assign m_len_error  = sel ? b_len_error  : a_len_error;
  assign m_abort      = sel ? b_abort      : a_abort;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] got_pl[$];
  logic [8:0] exp_pl[$];
  logic       got_done[$];
  logic       exp_done[$];
  int         n_lenerr = 0, n_abort = 0, exp_lenerr = 0, exp_abort = 0;
  logic [7:0] tx_q[$];
  logic [3:0]  e_type;
  logic        e_tx, e_rx, e_av, e_crcerr, av_pending;
  logic [7:0]  e_len;
  logic [47:0] e_addr;

  always @(negedge clk) begin
    if (m_pl_valid)  got_pl.push_back({m_pl_last, m_pl_data});
    if (m_pkt_done)  got_done.push_back(m_crc_error);
    if (m_len_error) n_lenerr++;
    if (m_abort)     n_abort++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] m_crc(input logic [23:0] c_in, input logic [7:0] b);
    logic [23:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[23] ^ b[i];
      c  = (c << 1) ^ (fb ? 24'h00065B : 24'h0);
    end
    return c;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "/pl_data"}, m_pl_data, 0);
    check({tag, "/pl_valid"}, m_pl_valid, 0);
    check({tag, "/pl_last"}, m_pl_last, 0);
    check({tag, "/pdu_type"}, m_pdu_type, 0);
    check({tag, "/tx_rx"}, {m_tx_add, m_rx_add}, 0);
    check({tag, "/pdu_len"}, m_pdu_len, 0);
    check({tag, "/adv_addr"}, m_adv_addr, 0);
    check({tag, "/addr_valid"}, m_addr_valid, 0);
    check({tag, "/pulses"}, {m_pkt_done, m_crc_error, m_len_error, m_abort}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sop, input int gap, output logic ab);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_sop   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_sop   = sop;
    #2;
    ab = m_abort;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  // Packet-level model: header fields, forwarded stream, done/crc outcome, len drop.
  task automatic build_pkt(input logic [7:0] h0, input logic [7:0] h1,
                           input logic [7:0] pl[$], input int flip_idx);
    int len, mx;
    logic [23:0] c;
    logic [7:0]  t;
    logic [7:0]  p[$];
    bit          flipped;
    p   = pl;
    len = sel ? int'(h1) : int'(h1 & 8'h3F);
    mx  = sel ? 255 : 37;
    tx_q = {};
    tx_q.push_back(h0);
    tx_q.push_back(h1);
    foreach (p[i]) tx_q.push_back(p[i]);
    c = 24'h555555;
    foreach (tx_q[i]) c = m_crc(c, tx_q[i]);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) t[j] = c[23 - 8*k - j];
      tx_q.push_back(t);
    end
    flipped = (flip_idx >= 0) && (flip_idx < p.size());
    if (flipped) begin
      p[flip_idx] = p[flip_idx] ^ 8'(1 << $urandom_range(7, 0));
      tx_q[2 + flip_idx] = p[flip_idx];
    end
    e_type = h0[3:0];
    e_tx = h0[6];
    e_rx = h0[7];
    e_len = 8'(len);
    e_crcerr = 1'b0;
    e_av = 1'b0;
    if (len > mx) begin
      exp_lenerr++;
    end else begin
      if (len >= 6) begin
        e_av = 1'b1;
        for (int i = 0; i < 6; i++) e_addr[8*i +: 8] = p[i];
      end
      foreach (p[i]) exp_pl.push_back({(i == len - 1), p[i]});
      exp_done.push_back(flipped);
      e_crcerr = flipped;
    end
    av_pending = e_av;
  endtask

  task automatic send_pkt(input int gapmax, input logic exp_ab);
    logic ab;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], (i == 0), (i == 0) ? 0 : int'($urandom_range(gapmax, 0)), ab);
      if (i == 0) check("abort_at_sop", ab, exp_ab);
      if (i == 6 && av_pending) check("addr_valid_before_6th", m_addr_valid, 0);
    end
  endtask

  task automatic check_all(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "/pl_count"}, got_pl.size(), exp_pl.size());
    for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++)
      check({tag, "/pl_byte"}, got_pl[i], exp_pl[i]);
    check({tag, "/done_count"}, got_done.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++)
      check({tag, "/crc_error_at_done"}, got_done[i], exp_done[i]);
    check({tag, "/len_error_count"}, n_lenerr, exp_lenerr);
    check({tag, "/abort_count"}, n_abort, exp_abort);
    check({tag, "/pdu_type"}, m_pdu_type, e_type);
    check({tag, "/tx_add"}, m_tx_add, e_tx);
    check({tag, "/rx_add"}, m_rx_add, e_rx);
    check({tag, "/pdu_len"}, m_pdu_len, e_len);
    check({tag, "/adv_addr"}, m_adv_addr, e_addr);
    check({tag, "/addr_valid"}, m_addr_valid, e_av);
    check({tag, "/crc_error_held"}, m_crc_error, e_crcerr);
    check({tag, "/idle_strobes"}, {m_pl_valid, m_pkt_done}, 0);
    got_pl = {};
    exp_pl = {};
    got_done = {};
    exp_done = {};
    n_lenerr = 0; exp_lenerr = 0;
    n_abort = 0;  exp_abort = 0;
  endtask

  function automatic void rand_pl(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] adv[$];
    logic [7:0] pl[$];
    logic       ab;
    int         len;
    sel = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_data = 8'h00;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    e_addr = '0;
    adv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hAA, 8'hBB, 8'hCC};
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_a");
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    got_pl = {}; got_done = {}; n_lenerr = 0; n_abort = 0;

    build_pkt(8'h40, 8'h09, adv, -1);
    send_pkt(0, 1'b0);
    check_all("adv_ind");

    build_pkt(8'h40, 8'h09, adv, 6);
    send_pkt(2, 1'b0);
    check_all("adv_ind_bitflip");

    rand_pl(38, pl);
    build_pkt(8'h00, 8'h26, pl, -1);
    send_pkt(1, 1'b0);
    check_all("len_over_max");
    build_pkt(8'h40, 8'h09, adv, -1);
    send_pkt(1, 1'b0);
    check_all("after_len_error");

    // Truncated packet: header + 4 address bytes, then a fresh sop.
    send_byte(8'h40, 1'b1, 0, ab);
    send_byte(8'h09, 1'b0, 0, ab);
    for (int i = 0; i < 4; i++) begin
      send_byte(adv[i], 1'b0, 0, ab);
      exp_pl.push_back({1'b0, adv[i]});
    end
    exp_abort = 1;
    build_pkt(8'h40, 8'h09, adv, -1);
    send_pkt(2, 1'b1);
    check_all("abort_restart");

    pl = {};
    build_pkt(8'h01, 8'h00, pl, -1);
    send_pkt(5, 1'b0);
    check_all("empty_pdu_gaps");

    // Back-to-back: second sop lands on the cycle after the last CRC byte.
    build_pkt(8'h40, 8'h09, adv, -1);
    send_pkt(0, 1'b0);
    rand_pl(12, pl);
    build_pkt(8'h42, 8'h0C, pl, -1);
    send_pkt(0, 1'b0);
    check_all("sop_in_done");

    for (int n = 0; n < 12; n++) begin
      for (int j = 0; j < int'($urandom_range(2, 0)); j++)
        send_byte(8'($urandom), 1'b0, int'($urandom_range(1, 0)), ab);
      len = int'($urandom_range(40, 0));
      rand_pl(len, pl);
      build_pkt(8'($urandom), {2'($urandom), 6'(len)}, pl,
                (len > 0 && ($urandom % 3) == 0) ? int'($urandom_range(len - 1, 0)) : -1);
      send_pkt(3, 1'b0);
      check_all("random_pkt");
    end

    sel = 1'b1;
    e_addr = '0;
    rand_pl(255, pl);
    build_pkt(8'h46, 8'hFF, pl, -1);
    send_pkt(1, 1'b0);
    check_all("ble5_len255");

    send_byte(8'h40, 1'b1, 0, ab);
    send_byte(8'hFF, 1'b0, 0, ab);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, 0, ab);
    check("mid_payload_streaming", m_pl_valid, 1'b1);
    rst_n_b = 1'b0;
    #1;
    check_zero("reset_mid_payload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
